// File: rtl/genie_split.sv
// Packet-aware 1-to-NO demultiplexer with a single registered output slot.
// Routes each packet by its header-beat destination; bad destinations are dropped and counted.
module genie_split #(
  parameter int NO    = 2,
  parameter int WIDTH = 8,
  parameter int CNTW  = 8,
  localparam int DBITS = (NO > 1) ? $clog2(NO) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_eop,
  input  logic [DBITS-1:0]          i_dest,
  output logic [NO-1:0][WIDTH-1:0]  o_data,
  output logic [NO-1:0]             o_valid,
  input  logic [NO-1:0]             i_ready,
  output logic [NO-1:0]             o_eop,
  output logic [CNTW-1:0]           o_drop_count
);

  typedef enum logic [1:0] {S_HEAD, S_LOCKED, S_DROP} state_t;

  localparam logic [DBITS:0] NO_V = (DBITS+1)'(NO);

  state_t            state;
  logic              slot_full;
  logic [WIDTH-1:0]  slot_data;
  logic              slot_eop;
  logic [DBITS-1:0]  slot_dest;
  logic [DBITS-1:0]  lock_dest;
  logic [CNTW-1:0]   drop_count;

  logic              dest_bad;
  logic              dropping;
  logic              drain;
  logic              accept;
  logic [DBITS-1:0]  eff_dest;

  always_comb begin
    dest_bad = ({1'b0, i_dest} >= NO_V);
    dropping = (state == S_DROP) || ((state == S_HEAD) && dest_bad);
    drain    = slot_full && i_ready[slot_dest];
    // Discarded beats never touch the slot, so they are accepted even when it is blocked.
    o_ready  = dropping || !slot_full || drain;
    accept   = i_valid && o_ready;
    eff_dest = (state == S_HEAD) ? i_dest : lock_dest;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HEAD;
      slot_full  <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drain)
        slot_full <= 1'b0;
      if (accept && !dropping) begin
        slot_full <= 1'b1;
        slot_data <= i_data;
        slot_eop  <= i_eop;
        slot_dest <= eff_dest;
      end
      if (accept) begin
        case (state)
          S_HEAD: begin
            if (dest_bad) begin
              if (drop_count != '1)
                drop_count <= drop_count + 1'b1;
              if (!i_eop)
                state <= S_DROP;
            end else begin
              lock_dest <= i_dest;
              if (!i_eop)
                state <= S_LOCKED;
            end
          end
          S_LOCKED: if (i_eop) state <= S_HEAD;
          S_DROP:   if (i_eop) state <= S_HEAD;
          default:  state <= S_HEAD;
        endcase
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NO; k++) begin
      o_data[k]  = slot_data;
      o_eop[k]   = slot_eop;
      o_valid[k] = slot_full && (slot_dest == DBITS'(k));
    end
  end

  assign o_drop_count = drop_count;

endmodule

// File: tb/tb_genie_split.sv
// Scoreboard bench for genie_split (NO=3, CNTW=2): routing, route lock, backpressure,
// drops with counter saturation, and reset in the middle of a packet.
module tb_genie_split;

  localparam int NO = 3;
  localparam int WIDTH = 8;
  localparam int CNTW = 2;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [WIDTH-1:0]         i_data = '0;
  logic                     i_valid = 1'b0;
  logic                     o_ready;
  logic                     i_eop = 1'b0;
  logic [1:0]               i_dest = '0;
  logic [NO-1:0][WIDTH-1:0] o_data;
  logic [NO-1:0]            o_valid;
  logic [NO-1:0]            i_ready = '1;
  logic [NO-1:0]            o_eop;
  logic [CNTW-1:0]          o_drop_count;

  genie_split #(.NO(NO), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_eop(i_eop), .i_dest(i_dest), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_eop(o_eop), .o_drop_count(o_drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       dest;
    logic [WIDTH-1:0] data;
    logic             eop;
  } beat_t;

  beat_t sb[$];
  int tests = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops one expectation per completed transfer and checks hold-while-stalled.
  logic [NO-1:0]            stall = '0;
  logic [NO-1:0][WIDTH-1:0] held_d;
  logic [NO-1:0]            held_e;

  always @(negedge clk) begin
    if (reset) begin
      stall = '0;
    end else begin
      check("onehot", 32'($countones(o_valid) <= 1), 1);
      for (int k = 0; k < NO; k++) begin
        if (stall[k]) begin
          check("hold_valid", 32'(o_valid[k]), 1);
          check("hold_data", 32'(o_data[k]), 32'(held_d[k]));
          check("hold_eop", 32'(o_eop[k]), 32'(held_e[k]));
        end
        if (o_valid[k] && i_ready[k]) begin
          check("sb_nonempty", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            beat_t e;
            e = sb.pop_front();
            check("out_dest", 32'(k), 32'(e.dest));
            check("out_data", 32'(o_data[k]), 32'(e.data));
            check("out_eop", 32'(o_eop[k]), 32'(e.eop));
          end
        end
        stall[k]  = o_valid[k] && !i_ready[k];
        held_d[k] = o_data[k];
        held_e[k] = o_eop[k];
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] dst, input logic e,
                      input logic [1:0] exp_dst, input bit drop, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    i_valid = 1'b1; i_data = d; i_dest = dst; i_eop = e;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        if (!drop) sb.push_back('{dest: exp_dst, data: d, eop: e});
        break;
      end
      waits++;
    end
    check("accept_timeout", 32'(ok), 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  int w;

  initial begin
    // Reset held with traffic present.
    i_valid = 1'b1; i_data = 8'h55; i_dest = 2'd1; i_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_drop", 32'(o_drop_count), 0);
    @(posedge clk); #1;

    // 4-beat packet to 2 then 1-beat packet to 0, back to back.
    for (int i = 0; i < 4; i++) begin
      send(8'hA0 + 8'(i), 2'd2, i == 3, 2'd2, 1'b0, w);
      check("tput_a", 32'(w), 0);
    end
    send(8'hB0, 2'd0, 1'b1, 2'd0, 1'b0, w);
    check("tput_b", 32'(w), 0);

    // Route lock: body beats carry a different i_dest.
    send(8'h10, 2'd1, 1'b0, 2'd1, 1'b0, w);
    send(8'h11, 2'd0, 1'b0, 2'd1, 1'b0, w);
    send(8'h12, 2'd0, 1'b1, 2'd1, 1'b0, w);
    check("lock_tput", 32'(w), 0);

    // Backpressure on output 1 for 5 cycles mid-packet.
    send(8'h20, 2'd1, 1'b0, 2'd1, 1'b0, w);
    i_ready = 3'b101;
    fork
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("bp_oready", 32'(o_ready), 0);
        end
        @(posedge clk); #1;
        i_ready = 3'b111;
      end
    join_none
    send(8'h21, 2'd2, 1'b0, 2'd1, 1'b0, w);
    check("bp_wait", 32'(w), 5);
    send(8'h22, 2'd0, 1'b0, 2'd1, 1'b0, w);
    check("bp_resume1", 32'(w), 0);
    send(8'h23, 2'd0, 1'b1, 2'd1, 1'b0, w);
    check("bp_resume2", 32'(w), 0);
    send(8'h30, 2'd0, 1'b1, 2'd0, 1'b0, w);
    check("bp_next_pkt", 32'(w), 0);

    // Drop: 2-beat packet to nonexistent output 3.
    check("drop_before", 32'(o_drop_count), 0);
    send(8'hE0, 2'd3, 1'b0, 2'd0, 1'b1, w);
    check("drop_rdy0", 32'(w), 0);
    send(8'hE1, 2'd1, 1'b1, 2'd0, 1'b1, w);
    check("drop_rdy1", 32'(w), 0);
    check("drop_count1", 32'(o_drop_count), 1);
    send(8'h40, 2'd0, 1'b1, 2'd0, 1'b0, w);
    check("after_drop", 32'(w), 0);

    // Dropped packet while the slot is blocked holding the previous eop beat.
    i_ready = 3'b011;
    send(8'hC0, 2'd2, 1'b1, 2'd2, 1'b0, w);
    send(8'hD0, 2'd3, 1'b1, 2'd0, 1'b1, w);
    check("drop_blocked_rdy", 32'(w), 0);
    check("drop_count2", 32'(o_drop_count), 2);
    repeat (2) @(posedge clk);
    #1 i_ready = 3'b111;

    // Three more bad packets: five total saturates the 2-bit counter.
    for (int i = 0; i < 3; i++) send(8'hF0 + 8'(i), 2'd3, 1'b1, 2'd0, 1'b1, w);
    check("drop_sat", 32'(o_drop_count), 3);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drain_mid", 32'(sb.size()), 0);

    // Reset mid-packet with beat 2 stuck in the slot.
    send(8'h60, 2'd1, 1'b0, 2'd1, 1'b0, w);
    send(8'h61, 2'd1, 1'b0, 2'd1, 1'b0, w);
    i_ready = 3'b101;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    i_ready = 3'b111;
    @(negedge clk);
    check("midrst_valid", 32'(o_valid), 0);
    @(posedge clk); #1;
    send(8'h70, 2'd0, 1'b1, 2'd0, 1'b0, w);
    check("midrst_hdr", 32'(w), 0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drain_end", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
